// File: rtl/canv_pix_read.sv
// Canvas pixel reader: signed (x,y) -> vram word address -> colour index, 1/2/4/8 bpp.
// In-bounds result 3+RD_LAT cycles after req (out of bounds: next cycle); req ignored while busy.
module canv_pix_read #(
  parameter int CORDW  = 16,
  parameter int WORD   = 32,
  parameter int ADDRW  = 14,
  parameter int COLRW  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic signed [CORDW-1:0] x,
  input  logic signed [CORDW-1:0] y,
  input  logic signed [CORDW-1:0] canv_w,
  input  logic signed [CORDW-1:0] canv_h,
  input  logic        [3:0]       canv_bpp,
  input  logic        [ADDRW-1:0] addr_base,
  output logic        [ADDRW-1:0] vram_addr,
  output logic                    vram_re,
  input  logic        [WORD-1:0]  vram_dout,
  output logic        [COLRW-1:0] cidx,
  output logic                    oob,
  output logic                    busy,
  output logic                    done
);

  localparam int LINW = 2 * CORDW;
  localparam int CNTW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADDR, S_WAIT} state_t;

  // Request snapshot; bpp is kept as log2 so shifts and masks derive from it.
  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic [CORDW-1:0] w;
    logic [1:0]       lg;
    logic [ADDRW-1:0] base;
  } req_t;

  state_t            state, state_nxt;
  req_t              rq, rq_nxt;
  logic [4:0]        pix_q, pix_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [ADDRW-1:0]  addr_nxt;
  logic              re_nxt, oob_nxt, busy_nxt, done_nxt;
  logic [COLRW-1:0]  cidx_nxt;

  logic [1:0]        lg_in;
  logic              out_of_bounds;
  logic [LINW-1:0]   lin_c, addr_full;
  logic [2:0]        sh_c;
  logic [4:0]        pix_c, shamt;
  logic [WORD-1:0]   word_sh;
  logic [COLRW-1:0]  mask_c, cidx_c;
  logic              unused_bits;

  always_comb begin
    case (canv_bpp)
      4'd1:    lg_in = 2'd0;
      4'd2:    lg_in = 2'd1;
      4'd4:    lg_in = 2'd2;
      4'd8:    lg_in = 2'd3;
      default: lg_in = 2'd2;
    endcase
  end

  assign out_of_bounds = x[CORDW-1] || y[CORDW-1] || (x >= canv_w) || (y >= canv_h);

  // Coordinates are known non-negative here, so the unsigned product is exact.
  assign lin_c     = LINW'(rq.y) * LINW'(rq.w) + LINW'(rq.x);
  assign sh_c      = 3'd5 - {1'b0, rq.lg};
  assign addr_full = LINW'(rq.base) + (lin_c >> sh_c);
  assign pix_c     = lin_c[4:0] & (5'h1F >> rq.lg);

  assign shamt   = pix_q << rq.lg;
  assign word_sh = vram_dout >> shamt;

  always_comb begin
    case (rq.lg)
      2'd0:    mask_c = COLRW'(8'h01);
      2'd1:    mask_c = COLRW'(8'h03);
      2'd2:    mask_c = COLRW'(8'h0F);
      default: mask_c = COLRW'(8'hFF);
    endcase
  end

  assign cidx_c      = word_sh[COLRW-1:0] & mask_c;
  assign unused_bits = ^{addr_full[LINW-1:ADDRW], word_sh[WORD-1:COLRW]};

  always_comb begin
    state_nxt = state;
    rq_nxt    = rq;
    pix_nxt   = pix_q;
    cnt_nxt   = cnt;
    addr_nxt  = vram_addr;
    re_nxt    = 1'b0;
    cidx_nxt  = cidx;
    oob_nxt   = oob;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (out_of_bounds) begin
            cidx_nxt = '0;
            oob_nxt  = 1'b1;
            done_nxt = 1'b1;
          end else begin
            rq_nxt    = '{x: x, y: y, w: canv_w, lg: lg_in, base: addr_base};
            busy_nxt  = 1'b1;
            state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        // Only the pixel-in-word index survives; the word part goes straight to the address.
        pix_nxt   = pix_c;
        addr_nxt  = addr_full[ADDRW-1:0];
        re_nxt    = 1'b1;
        state_nxt = S_ADDR;
      end
      S_ADDR: begin
        cnt_nxt   = CNTW'(RD_LAT);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) begin
          cidx_nxt  = cidx_c;
          oob_nxt   = 1'b0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rq        <= '0;
      pix_q     <= '0;
      cnt       <= '0;
      vram_addr <= '0;
      vram_re   <= 1'b0;
      cidx      <= '0;
      oob       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rq        <= rq_nxt;
      pix_q     <= pix_nxt;
      cnt       <= cnt_nxt;
      vram_addr <= addr_nxt;
      vram_re   <= re_nxt;
      cidx      <= cidx_nxt;
      oob       <= oob_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
